// File: rtl/linked_fifo_sched.sv
// linked_fifo_sched
//   Scheduler and front-end controller for a shared linked-list multi-queue FIFO.
//   Runs the FIFO initialisation sequence and holds off upstream pushes until it
//   completes and while the FIFO has no free space. It also keeps a word count for
//   each queue, because the FIFO only reports emptiness of the queue currently
//   addressed for pop. Non-empty, enabled queues are served round-robin. Popped
//   words are delivered on a valid/ready stream through a two-entry buffer, which
//   absorbs the FIFO's one-cycle read latency.
//
// Ports
//   clk, rst          clock; synchronous active-low reset
//   in_valid/in_fifo/in_data/in_ready
//                     upstream push stream (word plus destination queue)
//   sched_mask        per-queue pop enable
//   out_valid/out_fifo/out_data/out_ready
//                     downstream stream of popped words plus source queue
//   occupancy         per-queue word counts, LOG2_DEPTH+1 bits each
//   init_done         high once the FIFO is initialised and scheduling runs
//   lf_rst            active-high reset to the FIFO
//   lf_push/lf_push_fifo/lf_d
//                     FIFO write port
//   lf_pop/lf_pop_fifo/lf_q
//                     FIFO read port; lf_q is valid the cycle after lf_pop
//   lf_full           FIFO free list exhausted
module linked_fifo_sched #(
    parameter int unsigned WIDTH      = 8,
    parameter int unsigned DEPTH      = 32,
    parameter int unsigned FIFOS      = 8,
    parameter int unsigned LOG2_FIFOS = $clog2(FIFOS),
    parameter int unsigned LOG2_DEPTH = $clog2(DEPTH)
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                in_valid,
    input  logic [LOG2_FIFOS-1:0]               in_fifo,
    input  logic [WIDTH-1:0]                    in_data,
    output logic                                in_ready,
    input  logic [FIFOS-1:0]                    sched_mask,
    output logic                                out_valid,
    output logic [LOG2_FIFOS-1:0]               out_fifo,
    output logic [WIDTH-1:0]                    out_data,
    input  logic                                out_ready,
    output logic [FIFOS*(LOG2_DEPTH+1)-1:0]     occupancy,
    output logic                                init_done,
    output logic                                lf_rst,
    output logic                                lf_push,
    output logic                                lf_pop,
    output logic [LOG2_FIFOS-1:0]               lf_push_fifo,
    output logic [LOG2_FIFOS-1:0]               lf_pop_fifo,
    output logic [WIDTH-1:0]                    lf_d,
    input  logic [WIDTH-1:0]                    lf_q,
    input  logic                                lf_full
);

    localparam int unsigned CntW     = LOG2_DEPTH + 1;
    localparam int unsigned InitW    = $clog2(DEPTH + 2);
    localparam int unsigned InitLast = DEPTH + 1;

    typedef enum logic [1:0] {StReset, StInit, StRun} state_e;

    state_e                  state_q, state_d;
    logic [InitW-1:0]        init_cnt_q, init_cnt_d;
    logic [CntW-1:0]         cnt_q [FIFOS];
    logic [CntW-1:0]         cnt_d [FIFOS];
    logic [LOG2_FIFOS-1:0]   rr_q, rr_d;
    logic                    inflight_q;
    logic [LOG2_FIFOS-1:0]   inflight_fifo_q;

    // Two-entry output buffer of {queue, data}
    logic [WIDTH-1:0]        buf_data_q [2];
    logic [LOG2_FIFOS-1:0]   buf_fifo_q [2];
    logic                    buf_wp_q, buf_rp_q;
    logic [1:0]              buf_cnt_q, buf_cnt_d;

    logic                    run;
    logic                    push, pop;
    logic                    buf_wr, buf_rd;
    logic [1:0]              credit_used;
    logic [FIFOS-1:0]        eligible;
    logic                    grant_found;
    logic [LOG2_FIFOS-1:0]   grant;
    logic [LOG2_FIFOS:0]     scan;

    // ------------------------------------------------------------------
    // Control FSM: RESET holds the FIFO in reset; INIT waits out the FIFO's
    // free-list build; RUN enables pushes and scheduling.
    // ------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        init_cnt_d = '0;
        lf_rst     = 1'b0;
        run        = 1'b0;
        case (state_q)
            StReset: begin
                lf_rst  = 1'b1;
                state_d = StInit;
            end
            StInit: begin
                init_cnt_d = init_cnt_q + InitW'(1);
                if (init_cnt_q == InitW'(InitLast)) begin
                    state_d = StRun;
                end
            end
            StRun: begin
                run = 1'b1;
            end
            default: begin
                state_d = StReset;
            end
        endcase
    end

    assign init_done = run;

    // ------------------------------------------------------------------
    // Push path
    // ------------------------------------------------------------------
    assign in_ready     = run & ~lf_full;
    assign push         = in_valid & in_ready;
    assign lf_push      = push;
    assign lf_push_fifo = push ? in_fifo : '0;
    assign lf_d         = in_data;

    // ------------------------------------------------------------------
    // Pop path: eligibility uses registered counts, so a word pushed this
    // cycle cannot be popped before the next one.
    // ------------------------------------------------------------------
    always_comb begin
        for (int i = 0; i < int'(FIFOS); i++) begin
            eligible[i] = (cnt_q[i] != '0) & sched_mask[i];
        end
    end

    // First eligible queue at or after the round-robin pointer
    always_comb begin
        grant_found = 1'b0;
        grant       = '0;
        scan        = '0;
        for (int i = 0; i < int'(FIFOS); i++) begin
            scan = {1'b0, rr_q} + (LOG2_FIFOS+1)'(i);
            if (scan >= (LOG2_FIFOS+1)'(FIFOS)) begin
                scan = scan - (LOG2_FIFOS+1)'(FIFOS);
            end
            if (!grant_found && eligible[scan[LOG2_FIFOS-1:0]]) begin
                grant_found = 1'b1;
                grant       = scan[LOG2_FIFOS-1:0];
            end
        end
    end

    // Credits count the buffer as it will be after this cycle's read, so a
    // draining stream keeps one pop per cycle; never more than two words are
    // held between the buffer and the FIFO read in flight.
    assign buf_rd      = out_valid & out_ready;
    assign buf_wr      = inflight_q;
    assign credit_used = buf_cnt_q - {1'b0, buf_rd} + {1'b0, inflight_q};
    assign pop         = run & grant_found & (credit_used < 2'd2);
    assign lf_pop      = pop;
    assign lf_pop_fifo = pop ? grant : '0;

    always_comb begin
        rr_d = rr_q;
        if (pop) begin
            rr_d = (grant == LOG2_FIFOS'(FIFOS - 1)) ? '0 : grant + LOG2_FIFOS'(1);
        end
    end

    // Per-queue counts; a push and pop to the same queue cancel out
    always_comb begin
        for (int i = 0; i < int'(FIFOS); i++) begin
            cnt_d[i] = cnt_q[i];
            if ((push && in_fifo == LOG2_FIFOS'(i)) && !(pop && grant == LOG2_FIFOS'(i))) begin
                cnt_d[i] = cnt_q[i] + CntW'(1);
            end else if ((pop && grant == LOG2_FIFOS'(i)) &&
                         !(push && in_fifo == LOG2_FIFOS'(i))) begin
                cnt_d[i] = cnt_q[i] - CntW'(1);
            end
        end
    end

    always_comb begin
        occupancy = '0;
        for (int i = 0; i < int'(FIFOS); i++) begin
            occupancy[i*CntW +: CntW] = cnt_q[i];
        end
    end

    // ------------------------------------------------------------------
    // Output buffer
    // ------------------------------------------------------------------
    assign buf_cnt_d = buf_cnt_q + {1'b0, buf_wr} - {1'b0, buf_rd};
    assign out_valid = (buf_cnt_q != 2'd0);
    assign out_fifo  = buf_fifo_q[buf_rp_q];
    assign out_data  = buf_data_q[buf_rp_q];

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q         <= StReset;
            init_cnt_q      <= '0;
            rr_q            <= '0;
            inflight_q      <= 1'b0;
            inflight_fifo_q <= '0;
            buf_wp_q        <= 1'b0;
            buf_rp_q        <= 1'b0;
            buf_cnt_q       <= '0;
            for (int i = 0; i < 2; i++) begin
                buf_data_q[i] <= '0;
                buf_fifo_q[i] <= '0;
            end
            for (int i = 0; i < int'(FIFOS); i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            init_cnt_q <= init_cnt_d;
            rr_q       <= rr_d;
            inflight_q <= pop;
            if (pop) begin
                inflight_fifo_q <= grant;
            end
            if (buf_wr) begin
                buf_data_q[buf_wp_q] <= lf_q;
                buf_fifo_q[buf_wp_q] <= inflight_fifo_q;
                buf_wp_q             <= ~buf_wp_q;
            end
            if (buf_rd) begin
                buf_rp_q <= ~buf_rp_q;
            end
            buf_cnt_q <= buf_cnt_d;
            for (int i = 0; i < int'(FIFOS); i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

endmodule

// File: tb/tb_linked_fifo_sched.sv
module tb_linked_fifo_sched;

    localparam int WIDTH = 8;
    localparam int DEPTH = 32;
    localparam int FIFOS = 8;
    localparam int LF    = 3;
    localparam int LD    = 5;
    localparam int CW    = LD + 1;
    localparam int OW    = FIFOS * CW;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              in_valid = 1'b0;
    logic [LF-1:0]     in_fifo = '0;
    logic [WIDTH-1:0]  in_data = '0;
    logic              in_ready;
    logic [FIFOS-1:0]  sched_mask = '0;
    logic              out_valid;
    logic [LF-1:0]     out_fifo;
    logic [WIDTH-1:0]  out_data;
    logic              out_ready = 1'b0;
    logic [OW-1:0]     occupancy;
    logic              init_done;
    logic              lf_rst;
    logic              lf_push;
    logic              lf_pop;
    logic [LF-1:0]     lf_push_fifo;
    logic [LF-1:0]     lf_pop_fifo;
    logic [WIDTH-1:0]  lf_d;
    logic [WIDTH-1:0]  lf_q;
    logic              lf_full;

    linked_fifo_sched #(
        .WIDTH      (WIDTH),
        .DEPTH      (DEPTH),
        .FIFOS      (FIFOS),
        .LOG2_FIFOS (LF),
        .LOG2_DEPTH (LD)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_fifo      (in_fifo),
        .in_data      (in_data),
        .in_ready     (in_ready),
        .sched_mask   (sched_mask),
        .out_valid    (out_valid),
        .out_fifo     (out_fifo),
        .out_data     (out_data),
        .out_ready    (out_ready),
        .occupancy    (occupancy),
        .init_done    (init_done),
        .lf_rst       (lf_rst),
        .lf_push      (lf_push),
        .lf_pop       (lf_pop),
        .lf_push_fifo (lf_push_fifo),
        .lf_pop_fifo  (lf_pop_fifo),
        .lf_d         (lf_d),
        .lf_q         (lf_q),
        .lf_full      (lf_full)
    );

    initial forever #5 clk = ~clk;

    // Behavioural linked-list FIFO: per-queue rings, shared capacity DEPTH-FIFOS
    logic [WIDTH-1:0] mem [FIFOS][32];
    int               head [FIFOS];
    int               tail [FIFOS];
    int               model_total = 0;
    logic             pop_empty_seen = 1'b0;

    assign lf_full = (model_total >= DEPTH - FIFOS);

    always @(posedge clk) begin
        if (lf_rst) begin
            for (int i = 0; i < FIFOS; i++) begin
                head[i] <= 0;
                tail[i] <= 0;
            end
            model_total <= 0;
            lf_q        <= '0;
        end else begin
            if (lf_pop) begin
                if (init_done && head[lf_pop_fifo] == tail[lf_pop_fifo]) begin
                    pop_empty_seen <= 1'b1;
                end
                lf_q              <= mem[lf_pop_fifo][head[lf_pop_fifo]];
                head[lf_pop_fifo] <= (head[lf_pop_fifo] + 1) % 32;
            end
            if (lf_push) begin
                mem[lf_push_fifo][tail[lf_push_fifo]] <= lf_d;
                tail[lf_push_fifo]                    <= (tail[lf_push_fifo] + 1) % 32;
            end
            model_total <= model_total + (lf_push ? 1 : 0) - (lf_pop ? 1 : 0);
        end
    end

    // Monitors sampled on the falling edge
    logic [LF+WIDTH-1:0] rx [$];
    int                  pop_count = 0;

    always @(negedge clk) begin
        if (out_valid && out_ready) rx.push_back({out_fifo, out_data});
        if (lf_pop) pop_count <= pop_count + 1;
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic             vin;
        logic [LF-1:0]    vf;
        logic [WIDTH-1:0] vd;
        logic [FIFOS-1:0] mask;
        logic             e_pop;
        logic [LF-1:0]    e_pf;
        logic             e_ov;
        logic [LF-1:0]    e_of;
        logic [WIDTH-1:0] e_od;
        logic [OW-1:0]    e_occ;
    } vec_t;

    function automatic logic [OW-1:0] oc(input int q, input int n);
        logic [OW-1:0] v;
        v  = OW'(n);
        oc = v << (q * CW);
    endfunction

    function automatic vec_t mkv(input int vin, input int vf, input int vd, input int mask,
                                 input int e_pop, input int e_pf, input int e_ov,
                                 input int e_of, input int e_od, input logic [OW-1:0] e_occ);
        vec_t v;
        v.vin   = 1'(vin);
        v.vf    = LF'(vf);
        v.vd    = WIDTH'(vd);
        v.mask  = FIFOS'(mask);
        v.e_pop = 1'(e_pop);
        v.e_pf  = LF'(e_pf);
        v.e_ov  = 1'(e_ov);
        v.e_of  = LF'(e_of);
        v.e_od  = WIDTH'(e_od);
        v.e_occ = e_occ;
        return v;
    endfunction

    vec_t vecs [29];

    initial begin
        int rx0;
        int pc0;
        int k;
        logic [OW-1:0]       occ3;
        logic [LF+WIDTH-1:0] got;
        logic [LF+WIDTH-1:0] want;

        // Round-robin (rr starts at 0), refill, single word, same-queue push+pop
        vecs[0]  = mkv(1, 0, 'h10, 'h00, 0, 0, 0, 0, 0, '0);
        vecs[1]  = mkv(1, 2, 'h20, 'h00, 0, 0, 0, 0, 0, oc(0, 1));
        vecs[2]  = mkv(1, 5, 'h50, 'h00, 0, 0, 0, 0, 0, oc(0, 1) | oc(2, 1));
        vecs[3]  = mkv(0, 0, 0, 'hFF, 1, 0, 0, 0, 0, oc(0, 1) | oc(2, 1) | oc(5, 1));
        vecs[4]  = mkv(0, 0, 0, 'hFF, 1, 2, 0, 0, 0, oc(2, 1) | oc(5, 1));
        vecs[5]  = mkv(0, 0, 0, 'hFF, 1, 5, 1, 0, 'h10, oc(5, 1));
        vecs[6]  = mkv(0, 0, 0, 'hFF, 0, 0, 1, 2, 'h20, '0);
        vecs[7]  = mkv(0, 0, 0, 'hFF, 0, 0, 1, 5, 'h50, '0);
        vecs[8]  = mkv(1, 0, 'hA1, 'h00, 0, 0, 0, 0, 0, '0);
        vecs[9]  = mkv(1, 2, 'hB1, 'h00, 0, 0, 0, 0, 0, oc(0, 1));
        vecs[10] = mkv(1, 0, 'hA2, 'h00, 0, 0, 0, 0, 0, oc(0, 1) | oc(2, 1));
        vecs[11] = mkv(1, 2, 'hB2, 'h00, 0, 0, 0, 0, 0, oc(0, 2) | oc(2, 1));
        vecs[12] = mkv(0, 0, 0, 'hFF, 1, 0, 0, 0, 0, oc(0, 2) | oc(2, 2));
        vecs[13] = mkv(0, 0, 0, 'hFF, 1, 2, 0, 0, 0, oc(0, 1) | oc(2, 2));
        vecs[14] = mkv(0, 0, 0, 'hFF, 1, 0, 1, 0, 'hA1, oc(0, 1) | oc(2, 1));
        vecs[15] = mkv(0, 0, 0, 'hFF, 1, 2, 1, 2, 'hB1, oc(2, 1));
        vecs[16] = mkv(0, 0, 0, 'hFF, 0, 0, 1, 0, 'hA2, '0);
        vecs[17] = mkv(0, 0, 0, 'hFF, 0, 0, 1, 2, 'hB2, '0);
        vecs[18] = mkv(0, 0, 0, 'hFF, 0, 0, 0, 0, 0, '0);
        vecs[19] = mkv(1, 3, 'hA5, 'hFF, 0, 0, 0, 0, 0, '0);
        vecs[20] = mkv(0, 0, 0, 'hFF, 1, 3, 0, 0, 0, oc(3, 1));
        vecs[21] = mkv(0, 0, 0, 'hFF, 0, 0, 0, 0, 0, '0);
        vecs[22] = mkv(0, 0, 0, 'hFF, 0, 0, 1, 3, 'hA5, '0);
        vecs[23] = mkv(1, 3, 'h11, 'hFF, 0, 0, 0, 0, 0, '0);
        vecs[24] = mkv(1, 3, 'h22, 'hFF, 1, 3, 0, 0, 0, oc(3, 1));
        vecs[25] = mkv(0, 0, 0, 'hFF, 1, 3, 0, 0, 0, oc(3, 1));
        vecs[26] = mkv(0, 0, 0, 'hFF, 0, 0, 1, 3, 'h11, '0);
        vecs[27] = mkv(0, 0, 0, 'hFF, 0, 0, 1, 3, 'h22, '0);
        vecs[28] = mkv(0, 0, 0, 'hFF, 0, 0, 0, 0, 0, '0);

        // ---------------- reset values ----------------
        repeat (5) next_cycle();
        chk("rst in_ready", in_ready, 0);
        chk("rst out_valid", out_valid, 0);
        chk("rst out_fifo", out_fifo, 0);
        chk("rst out_data", out_data, 0);
        chk("rst occupancy", occupancy, 0);
        chk("rst init_done", init_done, 0);
        chk("rst lf_rst", lf_rst, 1);
        chk("rst lf_push", lf_push, 0);
        chk("rst lf_pop", lf_pop, 0);
        chk("rst lf_pop_fifo", lf_pop_fifo, 0);
        chk("rst lf_push_fifo", lf_push_fifo, 0);

        // ---------------- init sequence ----------------
        next_cycle();
        rst = 1'b1;
        #1;
        chk("init0 lf_rst", lf_rst, 1);
        chk("init0 init_done", init_done, 0);
        for (int c = 1; c <= DEPTH + 3; c++) begin
            next_cycle();
            chk($sformatf("init%0d lf_rst", c), lf_rst, 0);
            chk($sformatf("init%0d init_done", c), init_done, (c == DEPTH + 3) ? 1 : 0);
            chk($sformatf("init%0d in_ready", c), in_ready, (c == DEPTH + 3) ? 1 : 0);
            chk($sformatf("init%0d lf_pop", c), lf_pop, 0);
        end

        // ---------------- vector table ----------------
        out_ready = 1'b1;
        for (int i = 0; i < 29; i++) begin
            next_cycle();
            in_valid   = vecs[i].vin;
            in_fifo    = vecs[i].vf;
            in_data    = vecs[i].vd;
            sched_mask = vecs[i].mask;
            #1;
            chk($sformatf("v%0d in_ready", i), in_ready, 1);
            chk($sformatf("v%0d lf_push", i), lf_push, vecs[i].vin);
            if (vecs[i].vin) chk($sformatf("v%0d lf_push_fifo", i), lf_push_fifo, vecs[i].vf);
            chk($sformatf("v%0d lf_pop", i), lf_pop, vecs[i].e_pop);
            if (vecs[i].e_pop) chk($sformatf("v%0d lf_pop_fifo", i), lf_pop_fifo, vecs[i].e_pf);
            chk($sformatf("v%0d out_valid", i), out_valid, vecs[i].e_ov);
            if (vecs[i].e_ov) begin
                chk($sformatf("v%0d out_fifo", i), out_fifo, vecs[i].e_of);
                chk($sformatf("v%0d out_data", i), out_data, vecs[i].e_od);
            end
            chk($sformatf("v%0d occupancy", i), occupancy, vecs[i].e_occ);
        end

        // ---------------- back-pressure ----------------
        rx0 = rx.size();
        pc0 = pop_count;
        out_ready  = 1'b0;
        sched_mask = '1;
        for (int i = 0; i < 4; i++) begin
            next_cycle();
            in_valid = 1'b1;
            in_fifo  = 3'd1;
            in_data  = WIDTH'(8'h41 + i);
        end
        next_cycle();
        in_valid = 1'b0;
        repeat (5) next_cycle();
        chk("bp pops issued", pop_count - pc0, 2);
        chk("bp occupancy", occupancy, oc(1, 2));
        chk("bp out_valid", out_valid, 1);
        out_ready = 1'b1;
        k = 0;
        while (rx.size() - rx0 < 4 && k < 20) begin
            next_cycle();
            k++;
        end
        repeat (3) next_cycle();
        chk("bp delivered count", rx.size() - rx0, 4);
        for (int i = 0; i < 4; i++) begin
            want = {3'd1, WIDTH'(8'h41 + i)};
            got  = (rx0 + i < rx.size()) ? rx[rx0 + i] : '0;
            chk($sformatf("bp word%0d", i), got, want);
        end
        chk("bp occupancy drained", occupancy, 0);

        // ---------------- full ----------------
        out_ready  = 1'b0;
        sched_mask = '0;
        for (int i = 0; i < DEPTH - FIFOS; i++) begin
            next_cycle();
            in_valid = 1'b1;
            in_fifo  = LF'(i % FIFOS);
            in_data  = WIDTH'(i);
            #1;
            chk($sformatf("full push%0d in_ready", i), in_ready, 1);
        end
        next_cycle();
        in_fifo = 3'd0;
        in_data = 8'h99;
        #1;
        chk("full in_ready", in_ready, 0);
        chk("full lf_push", lf_push, 0);
        occ3 = '0;
        for (int q = 0; q < FIFOS; q++) occ3 = occ3 | oc(q, 3);
        chk("full occupancy", occupancy, occ3);
        pc0 = pop_count;
        next_cycle();
        in_valid   = 1'b0;
        sched_mask = '1;
        #1;
        chk("full resume lf_pop", lf_pop, 1);
        next_cycle();
        chk("full in_ready back", in_ready, 1);
        repeat (3) next_cycle();
        chk("full stalled pops", pop_count - pc0, 2);
        chk("pre-reset out_valid", out_valid, 1);

        // ---------------- mid-stream reset ----------------
        next_cycle();
        rst = 1'b0;
        next_cycle();
        chk("mrst out_valid", out_valid, 0);
        chk("mrst occupancy", occupancy, 0);
        chk("mrst lf_rst", lf_rst, 1);
        chk("mrst init_done", init_done, 0);
        chk("mrst in_ready", in_ready, 0);
        rst = 1'b1;
        k = 0;
        while (!init_done && k < 60) begin
            next_cycle();
            k++;
        end
        chk("mrst init cycles", k, DEPTH + 3);

        // Post-reset sanity word
        out_ready = 1'b1;
        rx0 = rx.size();
        next_cycle();
        in_valid = 1'b1;
        in_fifo  = 3'd6;
        in_data  = 8'h66;
        next_cycle();
        in_valid = 1'b0;
        k = 0;
        while (rx.size() == rx0 && k < 10) begin
            next_cycle();
            k++;
        end
        got = (rx.size() > rx0) ? rx[rx0] : '0;
        chk("post-reset word", got, {3'd6, 8'h66});
        chk("pop from empty queue", pop_empty_seen, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
